// File: rtl/bus_cycle_sequencer.sv
// Z80-style bus cycle sequencer: fetch/read/write/I-O cycles with T1,T2,TW,T3 timing.
// Define BUS_EXTERNAL_WAIT_EN to honour notWAIT; otherwise only the mandatory I/O wait is inserted.
module bus_cycle_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req_Fetch,
  input  logic        Req_Read,
  input  logic        Req_Write,
  input  logic        Req_In,
  input  logic        Req_Out,
  input  logic [15:0] Address,
  input  logic [7:0]  DataOut,
  input  logic [7:0]  BusDataIn,
  input  logic        notWAIT,
  output logic [15:0] BusAddress,
  output logic [7:0]  BusDataOut,
  output logic        BusDataOE,
  output logic        notM1,
  output logic        notMREQ,
  output logic        notIORQ,
  output logic        notRD,
  output logic        notWR,
  output logic [7:0]  DataIn,
  output logic        Done,
  output logic        Busy,
  output logic        Overrun
);

  typedef enum logic [2:0] {IDLE, T1, T2, TW, T3} state_t;
  typedef enum logic [2:0] {K_FETCH, K_READ, K_WRITE, K_IN, K_OUT} kind_t;

  // active-high internal view of the bus controls
  typedef struct packed {
    logic m1;
    logic mreq;
    logic iorq;
    logic rd;
    logic wr;
    logic oe;
  } strb_t;

  state_t     state, nxt_state;
  kind_t      kind, nxt_kind, pick;
  logic       io_owed;
  logic       ext_wait;
  logic [4:0] reqs;
  logic       any_req, multi_req;
  strb_t      strb, nxt_strb;

`ifdef BUS_EXTERNAL_WAIT_EN
  assign ext_wait = ~notWAIT;
`else
  logic unused_wait;
  assign unused_wait = notWAIT;
  assign ext_wait    = 1'b0;
`endif

  assign reqs      = {Req_Out, Req_In, Req_Write, Req_Read, Req_Fetch};
  assign any_req   = |reqs;
  assign multi_req = (reqs & (reqs - 5'd1)) != 5'd0;

  always_comb begin
    pick = K_OUT;
    if (Req_Fetch)      pick = K_FETCH;
    else if (Req_Read)  pick = K_READ;
    else if (Req_Write) pick = K_WRITE;
    else if (Req_In)    pick = K_IN;
  end

  always_comb begin
    nxt_state = state;
    nxt_kind  = kind;
    case (state)
      IDLE: if (any_req) begin
        nxt_state = T1;
        nxt_kind  = pick;
      end
      T1:      nxt_state = T2;
      T2, TW:  nxt_state = (io_owed || ext_wait) ? TW : T3;
      T3:      nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  // Strobes are a function of the state being entered, so they register cleanly.
  always_comb begin
    logic act, mid, is_mem, is_io, is_rdk, is_wrk;
    act    = nxt_state inside {T1, T2, TW, T3};
    mid    = nxt_state inside {T2, TW, T3};
    is_mem = nxt_kind inside {K_FETCH, K_READ, K_WRITE};
    is_io  = nxt_kind inside {K_IN, K_OUT};
    is_rdk = nxt_kind inside {K_FETCH, K_READ};
    is_wrk = nxt_kind inside {K_WRITE, K_OUT};
    nxt_strb      = '0;
    nxt_strb.m1   = (nxt_kind == K_FETCH) && (nxt_state inside {T1, T2, TW});
    nxt_strb.mreq = is_mem && act;
    nxt_strb.iorq = is_io && mid;
    nxt_strb.rd   = (is_rdk && act) || ((nxt_kind == K_IN) && mid);
    nxt_strb.wr   = is_wrk && mid;
    nxt_strb.oe   = is_wrk && act;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      kind       <= K_READ;
      io_owed    <= 1'b0;
      strb       <= '0;
      BusAddress <= 16'h0000;
      BusDataOut <= 8'h00;
      DataIn     <= 8'h00;
      Done       <= 1'b0;
      Busy       <= 1'b0;
      Overrun    <= 1'b0;
    end else begin
      state <= nxt_state;
      kind  <= nxt_kind;
      strb  <= nxt_strb;
      Busy  <= (nxt_state != IDLE);
      Done  <= (state == T3);
      if (state == IDLE && any_req) begin
        BusAddress <= Address;
        BusDataOut <= DataOut;
        io_owed    <= (pick == K_IN) || (pick == K_OUT);
        if (multi_req) Overrun <= 1'b1;
      end else if (nxt_state == TW) begin
        io_owed <= 1'b0;
      end
      if (state != IDLE && any_req) Overrun <= 1'b1;
      if (state == T3 && (kind inside {K_FETCH, K_READ, K_IN})) DataIn <= BusDataIn;
    end
  end

  assign notM1     = ~strb.m1;
  assign notMREQ   = ~strb.mreq;
  assign notIORQ   = ~strb.iorq;
  assign notRD     = ~strb.rd;
  assign notWR     = ~strb.wr;
  assign BusDataOE = strb.oe;

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// Directed bench for bus_cycle_sequencer; per-cycle expected strobe vectors are hand-computed.
module tb_bus_cycle_sequencer;
  logic        clk, reset;
  logic        Req_Fetch, Req_Read, Req_Write, Req_In, Req_Out;
  logic [15:0] Address;
  logic [7:0]  DataOut, BusDataIn;
  logic        notWAIT;
  logic [15:0] BusAddress;
  logic [7:0]  BusDataOut, DataIn;
  logic        BusDataOE, notM1, notMREQ, notIORQ, notRD, notWR, Done, Busy, Overrun;

  int n_chk = 0;
  int n_err = 0;

  bus_cycle_sequencer dut (
    .clk(clk), .reset(reset),
    .Req_Fetch(Req_Fetch), .Req_Read(Req_Read), .Req_Write(Req_Write),
    .Req_In(Req_In), .Req_Out(Req_Out),
    .Address(Address), .DataOut(DataOut), .BusDataIn(BusDataIn), .notWAIT(notWAIT),
    .BusAddress(BusAddress), .BusDataOut(BusDataOut), .BusDataOE(BusDataOE),
    .notM1(notM1), .notMREQ(notMREQ), .notIORQ(notIORQ), .notRD(notRD), .notWR(notWR),
    .DataIn(DataIn), .Done(Done), .Busy(Busy), .Overrun(Overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {notM1,notMREQ,notIORQ,notRD,notWR,BusDataOE,Busy,Done}
  task automatic bus(input string tag, input logic [7:0] exp);
    chk(tag, {24'h0, notM1, notMREQ, notIORQ, notRD, notWR, BusDataOE, Busy, Done}, {24'h0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [7:0] IDL = 8'hF8, DN = 8'hF9;
  localparam logic [7:0] RD  = 8'hAA, FT = 8'h2A;
  localparam logic [7:0] WR1 = 8'hBE, WR2 = 8'hB6;
  localparam logic [7:0] OU1 = 8'hFE, OU2 = 8'hD6;
  localparam logic [7:0] IN1 = 8'hFA, IN2 = 8'hCA;

  initial begin
    reset = 1'b1; notWAIT = 1'b1;
    {Req_Fetch, Req_Read, Req_Write, Req_In, Req_Out} = '0;
    Address = '0; DataOut = '0; BusDataIn = '0;
    tick();
    Req_Read = 1'b1;
    tick();
    reset = 1'b0; Req_Read = 1'b0;
    bus("rst_bus", IDL);
    chk("rst_addr", BusAddress, 16'h0000);
    chk("rst_dout", BusDataOut, 8'h00);
    chk("rst_din", DataIn, 8'h00);
    chk("rst_ovr", Overrun, 1'b0);
    tick();
    bus("rst_req_ignored", IDL);

    // plain read, no waits
    Address = 16'h1234; BusDataIn = 8'hA5; Req_Read = 1'b1; tick(); Req_Read = 1'b0;
    bus("rd_c1", RD); chk("rd_addr", BusAddress, 16'h1234); tick();
    bus("rd_c2", RD); tick();
    bus("rd_c3", RD); tick();
    bus("rd_c4", DN); chk("rd_data", DataIn, 8'hA5);
    BusDataIn = 8'h00; tick();
    bus("rd_c5", IDL); chk("rd_hold", DataIn, 8'hA5);

    // I/O write: one mandatory TW
    Address = 16'h00FE; DataOut = 8'h3C; Req_Out = 1'b1; tick(); Req_Out = 1'b0;
    bus("out_c1", OU1); chk("out_addr", BusAddress, 16'h00FE); chk("out_data", BusDataOut, 8'h3C); tick();
    bus("out_c2", OU2); tick();
    bus("out_c3", OU2); tick();
    bus("out_c4", OU2); tick();
    bus("out_c5", DN); chk("out_din_hold", DataIn, 8'hA5); tick();

    // I/O read
    Address = 16'h0080; BusDataIn = 8'h42; Req_In = 1'b1; tick(); Req_In = 1'b0;
    bus("in_c1", IN1); tick();
    bus("in_c2", IN2); tick();
    bus("in_c3", IN2); tick();
    bus("in_c4", IN2); tick();
    bus("in_c5", DN); chk("in_data", DataIn, 8'h42); tick();

    // fetch with notWAIT low for the samples ending cycles 2 and 3
    Address = 16'h0100; BusDataIn = 8'h5A; Req_Fetch = 1'b1; tick(); Req_Fetch = 1'b0;
    bus("ft_c1", FT); notWAIT = 1'b0; tick();
    bus("ft_c2", FT); tick();
`ifdef BUS_EXTERNAL_WAIT_EN
    bus("ft_c3", FT); tick();
    bus("ft_c4", FT); notWAIT = 1'b1; tick();
    bus("ft_c5", RD); tick();
    bus("ft_c6", DN); chk("ft_data", DataIn, 8'h5A); tick();
`else
    bus("ft_c3", RD); notWAIT = 1'b1; tick();
    bus("ft_c4", DN); chk("ft_data", DataIn, 8'h5A); tick();
`endif
    bus("ft_idle", IDL);
    chk("ovr_clean", Overrun, 1'b0);

    // simultaneous read+write, then In during T2
    Address = 16'h2000; DataOut = 8'h77; BusDataIn = 8'hC3;
    Req_Read = 1'b1; Req_Write = 1'b1; tick(); Req_Read = 1'b0; Req_Write = 1'b0;
    bus("pri_c1", RD); chk("pri_ovr", Overrun, 1'b1); tick();
    bus("pri_c2", RD); Req_In = 1'b1; tick(); Req_In = 1'b0;
    bus("pri_c3", RD); tick();
    bus("pri_c4", DN); chk("pri_data", DataIn, 8'hC3); tick();
    bus("pri_c5", IDL); chk("pri_ovr_sticky", Overrun, 1'b1);

    // reset in the middle of a write
    Address = 16'h3000; DataOut = 8'h11; Req_Write = 1'b1; tick(); Req_Write = 1'b0;
    bus("wrst_c1", WR1); tick();
    bus("wrst_c2", WR2); notWAIT = 1'b0; tick();
    bus("wrst_c3", WR2); reset = 1'b1; tick(); reset = 1'b0; notWAIT = 1'b1;
    bus("wrst_c4", IDL);
    chk("wrst_ovr", Overrun, 1'b0);
    chk("wrst_addr", BusAddress, 16'h0000);
    chk("wrst_din", DataIn, 8'h00);
    tick();
    bus("wrst_c5", IDL);

    // back-to-back: write requested in the read's Done cycle
    Address = 16'h4000; BusDataIn = 8'h9E; Req_Read = 1'b1; tick(); Req_Read = 1'b0;
    bus("b2b_c1", RD); tick();
    bus("b2b_c2", RD); tick();
    bus("b2b_c3", RD); tick();
    bus("b2b_c4", DN); chk("b2b_rdata", DataIn, 8'h9E);
    Address = 16'h4001; DataOut = 8'hE7; Req_Write = 1'b1; tick(); Req_Write = 1'b0;
    bus("b2b_c5", WR1); chk("b2b_waddr", BusAddress, 16'h4001); chk("b2b_wdata", BusDataOut, 8'hE7); tick();
    bus("b2b_c6", WR2); tick();
    bus("b2b_c7", WR2); tick();
    bus("b2b_c8", DN); chk("b2b_ovr", Overrun, 1'b0); tick();
    bus("b2b_c9", IDL);

    // In vs Out simultaneously: In wins
    Address = 16'h0055; BusDataIn = 8'h66; Req_In = 1'b1; Req_Out = 1'b1; tick();
    Req_In = 1'b0; Req_Out = 1'b0;
    bus("io_pri_c1", IN1); chk("io_pri_ovr", Overrun, 1'b1); tick();
    bus("io_pri_c2", IN2); tick();
    bus("io_pri_c3", IN2); tick();
    bus("io_pri_c4", IN2); tick();
    bus("io_pri_c5", DN); chk("io_pri_data", DataIn, 8'h66); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
